mem_responder: RTL

//  Memory-side responder for the accumulator CPU's MAR/MBR memory port.

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder_array.sv | 25 ++
 rtl/mem_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants and state encoding for the
// accumulator CPU memory port.
package mem_if_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Req/Ack memory bus between the CPU MAR/MBR
// and the memory responder.
interface mem_responder_if;
  import mem_if_pkg::*;

  logic              Req;
  logic              We;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic [DATA_W-1:0] RData;
  logic              Ack;
  logic              Err;
  logic              Busy;

  modport master (
    output Req, We, Addr, WData,
    input  RData, Ack, Err, Busy
  );

  modport slave (
    input  Req, We, Addr, WData,
    output RData, Ack, Err, Busy
  );

endinterface

// File: rtl/mem_responder_array.sv
// Word store: synchronous write, combinational
// read, contents survive reset.
module mem_array #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 16,
  parameter int AW     = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // storage update, no reset by design
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: request latch, wait-state
// counter, range check and registered response.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH       = mem_if_pkg::DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic              we_nx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  logic              wr_ok;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign accept  = (state_q == IDLE) && bus.Req;
  assign rd_addr = accept ? bus.Addr : addr_q;
  assign we_nx   = accept ? bus.We : we_q;
  assign rd_ok   = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_ok   = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);

  // a write commits only on the edge leaving RESP
  assign arr_we  = Rst_n && (state_q == RESP)
                && we_q && wr_ok;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (arr_we),
    .waddr_i (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (rd_addr[AW-1:0]),
    .rdata_o (arr_rdata)
  );

  // FSM state and wait counter register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: accept, count wait states, respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if ({1'b0, cnt_q} + 5'd1 == 5'(WAIT_STATES)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // read data lands on entry to RESP, clears after
  always_comb begin
    rdata_d = rdata_q;
    if (state_d == RESP && state_q != RESP)
      rdata_d = (!we_nx && rd_ok) ? arr_rdata : '0;
    else if (state_q == RESP)
      rdata_d = '0;
  end

  // request latches and read data register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.Addr;
        we_q    <= bus.We;
        wdata_q <= bus.WData;
      end
      rdata_q <= rdata_d;
    end
  end

  // bus outputs decoded from state
  always_comb begin
    bus.Ack   = (state_q == RESP);
    bus.Err   = (state_q == RESP) && !wr_ok;
    bus.Busy  = (state_q != IDLE);
    bus.RData = rdata_q;
  end

endmodule
